// File: rtl/eu_dispatch.sv
// rtl/eu_dispatch.sv - execution-unit dispatch: collect two operands, then issue to the ALU
//
// Pulls the head entry from the instruction queue and waits for both of its operands
// to arrive from the prepop stage. It then holds a stable issue request to the ALU
// until the ALU accepts it.
//
// Ports:
//   clk, reset                      clock; asynchronous active-high reset
//   iq_valid_i, iq_instr_i          iqueue head entry
//   iq_pop_o                        one-cycle pop pulse on ALU acceptance
//   op0/op1_data_i, _success_i      operand data and per-cycle valid
//   flush_i                         synchronous flush back to IDLE
//   alu_valid_o, alu_ready_i        issue handshake
//   alu_instr_o, alu_op0/op1_o      latched instruction and operands
//   stall_cnt_o                     saturating count of cycles spent in COLLECT
module eu_dispatch #(
  parameter int  EU_IDX              = 0,
  parameter int  STALL_W             = 8,
  parameter type type_iqueue_entry   = logic [31:0],
  parameter type type_exec_unit_data = logic [31:0]
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iq_valid_i,
  input  type_iqueue_entry   iq_instr_i,
  output logic               iq_pop_o,
  input  type_exec_unit_data op0_data_i,
  input  type_exec_unit_data op1_data_i,
  input  logic               op0_success_i,
  input  logic               op1_success_i,
  input  logic               flush_i,
  output logic               alu_valid_o,
  input  logic               alu_ready_i,
  output type_iqueue_entry   alu_instr_o,
  output type_exec_unit_data alu_op0_o,
  output type_exec_unit_data alu_op1_o,
  output logic [STALL_W-1:0] stall_cnt_o
);

  // EU_IDX only labels the instance; a negative index has nothing to build.
  if (EU_IDX < 0) begin : g_no_eu_idx
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic               got0_q, got1_q;
  logic               cap0, cap1;
  logic [STALL_W-1:0] stall_q;

  // A captured flag holds its data: later success pulses are dropped.
  assign cap0 = (state_q == COLLECT) && op0_success_i && !got0_q;
  assign cap1 = (state_q == COLLECT) && op1_success_i && !got1_q;

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (iq_valid_i) state_n = COLLECT;
      // Uses this cycle's captures so same-cycle arrivals still issue next cycle.
      COLLECT: if ((got0_q || op0_success_i) && (got1_q || op1_success_i)) state_n = ISSUE;
      ISSUE:   if (alu_ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush_i) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      got0_q      <= 1'b0;
      got1_q      <= 1'b0;
      stall_q     <= '0;
      alu_instr_o <= '0;
      alu_op0_o   <= '0;
      alu_op1_o   <= '0;
    end else begin
      state_q <= state_n;
      if (flush_i) begin
        got0_q  <= 1'b0;
        got1_q  <= 1'b0;
        stall_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (iq_valid_i) begin
              alu_instr_o <= iq_instr_i;
              got0_q      <= 1'b0;
              got1_q      <= 1'b0;
              stall_q     <= '0;
            end
          end
          COLLECT: begin
            if (cap0) begin
              alu_op0_o <= op0_data_i;
              got0_q    <= 1'b1;
            end
            if (cap1) begin
              alu_op1_o <= op1_data_i;
              got1_q    <= 1'b1;
            end
            if (state_n == COLLECT && stall_q != {STALL_W{1'b1}})
              stall_q <= stall_q + STALL_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign alu_valid_o = (state_q == ISSUE);
  // Flush wins over acceptance: the entry stays in the iqueue.
  assign iq_pop_o    = alu_valid_o && alu_ready_i && !flush_i;
  assign stall_cnt_o = stall_q;

endmodule

// File: doc/eu_dispatch.md
EU_DISPATCH -- requirements
Module: eu_dispatch

Interface
REQ-001 SHALL have parameter EU_IDX, default 0, index of the owning execution unit (informational, drives no logic).
REQ-002 SHALL have parameter STALL_W, default 8, width of the stall counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port iq_valid_i  input  1  iqueue head entry valid.
REQ-006 SHALL have port iq_instr_i  input  type_iqueue_entry  iqueue head instruction.
REQ-007 SHALL have port iq_pop_o  output  1  one-cycle pop pulse to iqueue.
REQ-008 SHALL have port op0_data_i / op1_data_i  input  type_exec_unit_data  operands from the prepop stage.
REQ-009 SHALL have port op0_success_i / op1_success_i  input  1  operand valid this cycle.
REQ-010 SHALL have port flush_i  input  1  synchronous pipeline flush.
REQ-011 SHALL have port alu_valid_o  output  1  issue request to ALU.
REQ-012 SHALL have port alu_ready_i  input  1  ALU accepts issue.
REQ-013 SHALL have port alu_instr_o  output  type_iqueue_entry  latched instruction.
REQ-014 SHALL have port alu_op0_o / alu_op1_o  output  type_exec_unit_data  latched operands.
REQ-015 SHALL have port stall_cnt_o  output  STALL_W  cycles spent waiting on operands for the current instruction.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, ISSUE.
REQ-017 IDLE: SHALL go to COLLECT on the edge where iq_valid_i=1, latching iq_instr_i into alu_instr_o, clearing both captured flags and stall_cnt_o.
REQ-018 COLLECT: SHALL latch opX_data_i into alu_opX_o and set captured flag X on any cycle where opX_success_i=1 and flag X is clear; a set flag SHALL hold its data against later success pulses.
REQ-019 COLLECT: SHALL go to ISSUE on the edge where both flags are set after that cycle's captures, including both operands arriving in the same cycle; alu_valid_o SHALL rise the following cycle (1-cycle latency from last operand).
REQ-020 COLLECT: stall_cnt_o SHALL increment by 1 each cycle the FSM stays in COLLECT, saturating at 2^STALL_W-1 without wrap.
REQ-021 ISSUE: alu_valid_o=1; alu_instr_o, alu_op0_o and alu_op1_o SHALL stay stable until alu_valid_o & alu_ready_i.
REQ-022 ISSUE: on alu_valid_o & alu_ready_i, iq_pop_o SHALL be 1 combinationally in that cycle only, and the FSM SHALL go to IDLE.
REQ-023 iq_pop_o SHALL be 0 in all other states and cycles.
REQ-024 alu_valid_o SHALL be 1 only in ISSUE.
REQ-025 flush_i=1 SHALL send the FSM to IDLE next edge from any state, clear flags and stall_cnt_o, and suppress iq_pop_o that cycle even if alu_ready_i=1; flush SHALL take priority over every other transition.
REQ-026 Operand success inputs SHALL be ignored in IDLE and ISSUE.
REQ-027 iq_instr_i changes while in COLLECT or ISSUE SHALL NOT affect alu_instr_o.

Reset
REQ-028 While reset=1, asynchronously: FSM=IDLE, flags=0, alu_valid_o=0, iq_pop_o=0, stall_cnt_o=0, alu_instr_o/alu_op0_o/alu_op1_o=0.
REQ-029 Reset asserted mid-COLLECT or mid-ISSUE SHALL discard the in-flight instruction with no pop; the first active edge after deassertion SHALL be evaluated from IDLE.

Verification
REQ-030 iq_valid_i=1 at cycle 0; op0 (0x11) and op1 (0x22) succeed together at cycle 1 -> alu_valid_o=1 at cycle 2 with op0=0x11, op1=0x22; alu_ready_i=1 at cycle 2 -> iq_pop_o=1 at cycle 2 only.
REQ-031 op0 succeeds (0xA) at cycle 1, op0 pulses again (0xB) at cycle 2, op1 (0xC) at cycle 4 -> alu_op0_o=0xA, alu_valid_o rises at cycle 5, stall_cnt_o=3 in the last COLLECT cycle.
REQ-032 ISSUE with alu_ready_i=0 for 5 cycles -> alu_valid_o and all data held constant, iq_pop_o=0 throughout; alu_ready_i=1 -> single pop pulse.
REQ-033 STALL_W=2, operands withheld 6 cycles -> stall_cnt_o reaches 3 and holds at 3.
REQ-034 flush_i=1 in ISSUE together with alu_ready_i=1 -> iq_pop_o=0, alu_valid_o=0 next cycle, FSM in IDLE.
REQ-035 reset pulsed asynchronously mid-COLLECT -> all outputs 0 immediately; next iq_valid_i restarts from IDLE with stall_cnt_o=0.
